// File: rtl/seg_scan_decoder_if.sv
// Bus between a multiplexed 7-segment display scanner and its decoder.
// The master drives the scanned segment/digit lines. The slave returns
// the decoded frame and the error status.
interface seg_scan_decoder_if;
   logic [7:0]  seg_in;       // active-low segments, bit7 = dp, bits6:0 = g..a
   logic [3:0]  dig_in;       // active-low digit enables, bit0 = rightmost
   logic [15:0] value;        // last complete frame, digit n in bits 4n+3:4n
   logic [3:0]  dp_out;       // decimal point per digit, 1 = lit
   logic [3:0]  blank;        // per-digit blank flag
   logic        frame_valid;  // one-cycle pulse when a frame is published
   logic        err;          // one-cycle pulse on an accepted illegal pattern
   logic [7:0]  err_cnt;      // saturating error count (0 when disabled)

   modport master (
      output seg_in, dig_in,
      input  value, dp_out, blank, frame_valid, err, err_cnt
   );

   modport slave (
      input  seg_in, dig_in,
      output value, dp_out, blank, frame_valid, err, err_cnt
   );
endinterface

// File: rtl/seg_scan_decoder.sv
// Decoder that reads a scanned 4-digit 7-segment display back into
// numbers. Each digit is debounced over STABLE_CYCLES identical samples.
// Accepted digits collect in shadow slots. A full frame is published
// atomically once all four digits have been seen.
// Optional feature: define SEG_SCAN_DECODER_ERRCNT_EN to build the
// saturating err_cnt counter. Without it, err_cnt is tied to 00h.
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4   // legal range 2..255
) (
   input  logic               clk,
   input  logic               rst_n,
   seg_scan_decoder_if.slave  bus
);

   typedef enum logic [1:0] {S_WAIT, S_FILTER, S_HOLD} state_t;

   localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

   state_t      state_q,        state_d;
   logic [7:0]  seg_r_q,        seg_r_d;
   logic [3:0]  dig_r_q,        dig_r_d;
   logic [7:0]  cnt_q,          cnt_d;
   logic [7:0]  samp_seg_q,     samp_seg_d;
   logic [3:0]  samp_dig_q,     samp_dig_d;
   logic [15:0] shadow_val_q,   shadow_val_d;
   logic [3:0]  shadow_dp_q,    shadow_dp_d;
   logic [3:0]  shadow_blank_q, shadow_blank_d;
   logic [3:0]  mask_q,         mask_d;
   logic [15:0] value_q,        value_d;
   logic [3:0]  dp_q,           dp_d;
   logic [3:0]  blank_q,        blank_d;
   logic        fv_q,           fv_d;
   logic        err_q,          err_d;

   logic        accept;
   logic        same;
   logic        start;
   logic [5:0]  dec;         // {legal, blank, nibble}
   logic [3:0]  sel;
   logic [3:0]  mask_next;

   // Maps a segment pattern to {legal, blank, nibble}. Unknown patterns return 0.
   function automatic logic [5:0] decode(input logic [6:0] s);
      logic [5:0] r;
      case (s)
         7'h40:   r = {2'b10, 4'h0};
         7'h79:   r = {2'b10, 4'h1};
         7'h24:   r = {2'b10, 4'h2};
         7'h30:   r = {2'b10, 4'h3};
         7'h19:   r = {2'b10, 4'h4};
         7'h12:   r = {2'b10, 4'h5};
         7'h02:   r = {2'b10, 4'h6};
         7'h78:   r = {2'b10, 4'h7};
         7'h00:   r = {2'b10, 4'h8};
         7'h10:   r = {2'b10, 4'h9};
         7'h20:   r = {2'b10, 4'hA};
         7'h43:   r = {2'b10, 4'hB};
         7'h46:   r = {2'b10, 4'hC};
         7'h21:   r = {2'b10, 4'hD};
         7'h06:   r = {2'b10, 4'hE};
         7'h0E:   r = {2'b10, 4'hF};
         7'h7F:   r = {2'b11, 4'h0};
         default: r = 6'b00_0000;
      endcase
      return r;
   endfunction

   // Next-state logic: input capture, debounce FSM, shadow slots and frame publish.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      seg_r_d        = bus.seg_in;
      dig_r_d        = bus.dig_in;
      state_d        = state_q;
      cnt_d          = cnt_q;
      samp_seg_d     = samp_seg_q;
      samp_dig_d     = samp_dig_q;
      shadow_val_d   = shadow_val_q;
      shadow_dp_d    = shadow_dp_q;
      shadow_blank_d = shadow_blank_q;
      mask_d         = mask_q;
      value_d        = value_q;
      dp_d           = dp_q;
      blank_d        = blank_q;
      fv_d           = 1'b0;
      err_d          = 1'b0;
      accept         = 1'b0;

      same  = (seg_r_q == samp_seg_q) && (dig_r_q == samp_dig_q);
      start = $onehot(~dig_r_q);

      case (state_q)
         S_WAIT: begin
            if (start) begin
               state_d    = S_FILTER;
               cnt_d      = 8'd1;
               samp_seg_d = seg_r_q;
               samp_dig_d = dig_r_q;
            end
         end
         S_FILTER, S_HOLD: begin
            if (same) begin
               // HOLD simply parks here, so a held digit is never accepted twice.
               if (state_q == S_FILTER) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == STABLE_M1) begin
                     accept  = 1'b1;
                     state_d = S_HOLD;
                  end
               end
            end else if (start) begin
               state_d    = S_FILTER;
               cnt_d      = 8'd1;
               samp_seg_d = seg_r_q;
               samp_dig_d = dig_r_q;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 8'd0;
            end
         end
         default: state_d = S_WAIT;
      endcase

      // The sample is one-hot low whenever the FSM can accept, so sel names one slot.
      dec       = decode(samp_seg_q[6:0]);
      sel       = ~samp_dig_q;
      mask_next = mask_q | sel;

      if (accept) begin
         if (dec[5]) begin
            for (int i = 0; i < 4; i++) begin
               if (sel[i]) begin
                  shadow_val_d[4*i +: 4] = dec[3:0];
                  shadow_dp_d[i]         = ~samp_seg_q[7];
                  shadow_blank_d[i]      = dec[4];
               end
            end
            // The frame is built from the _d copies, so it includes the digit accepted now.
            if (mask_next == 4'b1111) begin
               value_d = shadow_val_d;
               dp_d    = shadow_dp_d;
               blank_d = shadow_blank_d;
               fv_d    = 1'b1;
               mask_d  = 4'b0000;
            end else begin
               mask_d  = mask_next;
            end
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      if (!rst_n) begin
         state_q        <= S_WAIT;
         seg_r_q        <= 8'hFF;
         dig_r_q        <= 4'hF;
         cnt_q          <= 8'd0;
         samp_seg_q     <= 8'hFF;
         samp_dig_q     <= 4'hF;
         // NOTE: shadow slots are reset too, so a partial frame can never leak past a reset.
         shadow_val_q   <= 16'h0000;
         shadow_dp_q    <= 4'b0000;
         shadow_blank_q <= 4'b0000;
         mask_q         <= 4'b0000;
         value_q        <= 16'h0000;
         dp_q           <= 4'b0000;
         blank_q        <= 4'b1111;
         fv_q           <= 1'b0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         seg_r_q        <= seg_r_d;
         dig_r_q        <= dig_r_d;
         cnt_q          <= cnt_d;
         samp_seg_q     <= samp_seg_d;
         samp_dig_q     <= samp_dig_d;
         shadow_val_q   <= shadow_val_d;
         shadow_dp_q    <= shadow_dp_d;
         shadow_blank_q <= shadow_blank_d;
         mask_q         <= mask_d;
         value_q        <= value_d;
         dp_q           <= dp_d;
         blank_q        <= blank_d;
         fv_q           <= fv_d;
         err_q          <= err_d;
      end
   end

   assign bus.value       = value_q;
   assign bus.dp_out      = dp_q;
   assign bus.blank       = blank_q;
   assign bus.frame_valid = fv_q;
   assign bus.err         = err_q;

`ifdef SEG_SCAN_DECODER_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   // Saturating error count, stepped together with the err pulse.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
   end

   // Error counter register. Only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) err_cnt_q <= 8'h00;
      else        err_cnt_q <= err_cnt_d;
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder. Stimulus is a sequence of
// "display steps" (segment byte, digit enables, duration). A step-level
// reference model predicts accepted digits, frames and error pulses.
// An independent monitor pops the predictions whenever the DUT pulses
// frame_valid or err.
module tb_seg_scan_decoder;

   localparam int SC = 4;

   typedef struct {
      logic [15:0] value;
      logic [3:0]  dp;
      logic [3:0]  blank;
   } frame_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   seg_scan_decoder_if bus ();

   seg_scan_decoder #(.STABLE_CYCLES(SC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   // Segment codes for hex digits 0..F (bits 6:0, active low)
   logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h20, 7'h43, 7'h46, 7'h21, 7'h06, 7'h0E};

   // Reference model state
   logic [3:0] m_val [4];
   logic [3:0] m_dp, m_blank, m_mask;
   int         m_errs;
   frame_t     cur;
   frame_t     exp_q [$];
   int         err_q [$];
   logic [7:0] prev_s;
   logic [3:0] prev_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void lookup(input logic [6:0] s, output bit legal, output bit blk,
                                  output logic [3:0] nib);
      legal = 0; blk = 0; nib = 4'h0;
      if (s == 7'h7F) begin
         legal = 1; blk = 1;
      end else begin
         for (int k = 0; k < 16; k++)
            if (hex_tbl[k] == s) begin legal = 1; nib = 4'(k); end
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 4; k++) m_val[k] = 4'h0;
      m_dp = 4'b0; m_blank = 4'b0; m_mask = 4'b0; m_errs = 0;
      cur.value = 16'h0000; cur.dp = 4'b0000; cur.blank = 4'b1111;
   endfunction

   // One digit shown for n cycles, delimited by different neighbours, is accepted iff n >= SC.
   function automatic void model_step(input logic [7:0] s, input logic [3:0] d, input int n);
      bit legal, blk;
      logic [3:0] nib;
      int idx;
      frame_t f;
      if ($countones(4'(~d)) != 1 || n < SC) return;
      idx = 0;
      for (int k = 0; k < 4; k++) if (!d[k]) idx = k;
      lookup(s[6:0], legal, blk, nib);
      if (legal) begin
         m_val[idx] = nib; m_dp[idx] = ~s[7]; m_blank[idx] = blk; m_mask[idx] = 1'b1;
         if (m_mask == 4'b1111) begin
            f.value = {m_val[3], m_val[2], m_val[1], m_val[0]};
            f.dp = m_dp; f.blank = m_blank;
            exp_q.push_back(f);
            m_mask = 4'b0;
         end
      end else begin
         if (m_errs < 255) m_errs++;
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
         err_q.push_back(m_errs);
`else
         err_q.push_back(0);
`endif
      end
   endfunction

   task automatic drive(input logic [7:0] s, input logic [3:0] d, input int n);
      model_step(s, d, n);
      bus.seg_in = s; bus.dig_in = d;
      prev_s = s; prev_d = d;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Show a digit. A one-cycle all-off gap is inserted if requested or if needed to keep steps distinct.
   task automatic scan(input logic [7:0] s, input logic [3:0] d, input int n, input bit gap);
      if (gap || (s == prev_s && d == prev_d)) drive(8'hFF, 4'hF, 1);
      drive(s, d, n);
   endtask

   task automatic idle(input int n);
      drive(8'hFF, 4'hF, n);
   endtask

   task automatic do_reset();
      idle(4);
      check("queues_drained_before_reset", exp_q.size() + err_q.size(), 0);
      rst_n = 1'b0;
      model_clear();
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
   endtask

   function automatic logic [6:0] rand_illegal();
      logic [6:0] r;
      bit legal, blk;
      logic [3:0] nib;
      do begin
         r = 7'($urandom_range(0, 127));
         lookup(r, legal, blk, nib);
      end while (legal);
      return r;
   endfunction

   // Monitor: pops predictions on DUT pulses and checks the outputs never change otherwise.
   initial begin
      frame_t f;
      int e;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (bus.frame_valid) begin
            if (exp_q.size() == 0) check("unexpected_frame_valid", 1, 0);
            else begin
               f = exp_q.pop_front();
               check("frame_value", bus.value, f.value);
               check("frame_dp", bus.dp_out, f.dp);
               check("frame_blank", bus.blank, f.blank);
               cur = f;
            end
         end else begin
            check("held_value", bus.value, cur.value);
            check("held_dp_blank", {bus.dp_out, bus.blank}, {cur.dp, cur.blank});
         end
         if (bus.err) begin
            if (err_q.size() == 0) check("unexpected_err", 1, 0);
            else begin
               e = err_q.pop_front();
               check("err_cnt_at_err", bus.err_cnt, e);
            end
         end
      end
   end

   // Watchdog: the stimulus is finite, so reaching this limit means something hung.
   initial begin
      #2ms;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] dsel [6];
      logic [7:0] s;
      logic [3:0] d;
      dsel = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF, 4'hC};
      bus.seg_in = 8'hFF; bus.dig_in = 4'hF;
      prev_s = 8'hFF; prev_d = 4'hF;
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_value", bus.value, 16'h0000);
      check("rst_dp_out", bus.dp_out, 4'b0000);
      check("rst_blank", bus.blank, 4'b1111);
      check("rst_frame_valid", bus.frame_valid, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_err_cnt", bus.err_cnt, 8'h00);
      @(posedge clk); #1;

      // Clean scan of 0,1,2,3
      scan(8'hC0, 4'hE, 6, 0); scan(8'hF9, 4'hD, 6, 0);
      scan(8'hA4, 4'hB, 6, 0); scan(8'hB0, 4'h7, 6, 0);
      idle(3);

      // Digit 2 shown one cycle short, then a stable pass
      scan(8'hC0, 4'hE, 6, 1); scan(8'hF9, 4'hD, 6, 1);
      scan(8'h86, 4'hB, SC - 1, 1); scan(8'hB0, 4'h7, 6, 1);
      idle(3);
      scan(8'h86, 4'hB, SC, 1);
      idle(3);

      // Blank digit among hex, dp on digit 0 and exact-threshold accept
      scan(8'h00, 4'hE, SC, 0); scan(8'hFF, 4'hD, 5, 0);
      scan(8'h90, 4'hB, 5, 0); scan(8'hA0, 4'h7, SC + 5, 0);
      idle(3);

      // Illegal pattern, then complete the frame
      scan(8'hFE, 4'hE, 6, 1);
      scan(8'hC0, 4'hE, 6, 1); scan(8'hF9, 4'hD, 6, 0);
      scan(8'hA4, 4'hB, 6, 0); scan(8'hB0, 4'h7, 6, 0);

      // Two digits low: never accepted
      scan(8'hC0, 4'hC, 20, 1);
      idle(3);

      // Reset mid-frame discards partial frame
      scan(8'h80, 4'hE, 6, 1); scan(8'h80, 4'hD, 6, 1); scan(8'h80, 4'hB, 6, 1);
      do_reset();
      scan(8'h92, 4'hE, 6, 0); scan(8'h82, 4'hD, 6, 0);
      scan(8'hF8, 4'hB, 6, 0); scan(8'h80, 4'h7, 6, 0);
      idle(3);

      // Error saturation
      for (int i = 0; i < 260; i++)
         scan({1'($urandom_range(0, 1)), rand_illegal()}, dsel[$urandom_range(0, 3)], SC, 1);

      // Randomized scans
      for (int i = 0; i < 400; i++) begin
         d = dsel[$urandom_range(0, 5)];
         if (i % 50 == 7) d = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0, 1:    s = {1'($urandom_range(0, 1)), rand_illegal()};
            2:       s = {1'($urandom_range(0, 1)), 7'h7F};
            default: s = {1'($urandom_range(0, 1)), hex_tbl[$urandom_range(0, 15)]};
         endcase
         scan(s, d, $urandom_range(1, SC + 4), 1'($urandom_range(0, 1)));
      end

      idle(10);
      check("frames_outstanding", exp_q.size(), 0);
      check("errs_outstanding", err_q.size(), 0);
`ifdef SEG_SCAN_DECODER_ERRCNT_EN
      check("final_err_cnt", bus.err_cnt, 8'hFF);
`else
      check("final_err_cnt", bus.err_cnt, 8'h00);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, giving the consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port seg_in  input  8  scanned display segment bus, active-low, bit7 = dp, bits6:0 = g..a.
REQ-005 SHALL have port dig_in  input  4  scanned digit enables, active-low, bit0 = rightmost digit.
REQ-006 SHALL have port value  output  16  last complete decoded frame, digit n in bits 4n+3:4n.
REQ-007 SHALL have port dp_out  output  4  decimal-point state per digit of the last frame, 1 = lit.
REQ-008 SHALL have port blank  output  4  per-digit blank flag of the last frame.
REQ-009 SHALL have port frame_valid  output  1  one-cycle pulse when value/dp_out/blank update.
REQ-010 SHALL have port err  output  1  one-cycle pulse on an accepted pattern that is neither hex nor blank.
REQ-011 SHALL have port err_cnt  output  8  saturating count of err pulses (see Configuration).

Function
REQ-012 SHALL decode bits6:0 only: 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 20->A, 43->B, 46->C, 21->D, 06->E, 0E->F (hex); 7F -> blank, nibble 0.
REQ-013 SHALL register seg_in and dig_in once before all logic (input latency 1 cycle).
REQ-014 SHALL run FSM WAIT / FILTER / HOLD; reset state WAIT.
REQ-015 WAIT: on exactly one dig_in bit low, load stability counter with 1, latch sample, go FILTER.
REQ-016 FILTER: each cycle with identical registered seg_in and dig_in, increment counter; any change -> restart FILTER with new sample if exactly one digit low, else WAIT.
REQ-017 FILTER: when counter reaches STABLE_CYCLES, accept the digit in that same cycle and go HOLD.
REQ-018 HOLD: stay until registered seg_in or dig_in changes, then behave as WAIT in that cycle; a held digit is never accepted twice.
REQ-019 Zero or multiple dig_in bits low SHALL never be accepted and force WAIT.
REQ-020 Accept of a legal pattern SHALL write nibble, dp (= !seg bit7) and blank flag into shadow slot of that digit and set its mask bit; re-accepting a digit before frame completion overwrites its slot.
REQ-021 Accept of an illegal pattern SHALL pulse err next cycle and leave shadow and mask unchanged.
REQ-022 When mask reaches 1111, SHALL copy all shadow slots to value/dp_out/blank, pulse frame_valid, clear mask, all in the cycle after the fourth accept.
REQ-023 Accept and frame completion in the same cycle SHALL include the newly accepted digit in the frame.
REQ-024 Outputs SHALL only change at frame_valid; partial frames are never visible.

Reset
REQ-025 On rst_n low at a clock edge: FSM WAIT, counter 0, mask 0000, shadow 0, input registers FFh/Fh.
REQ-026 Reset values: value 0000h, dp_out 0000, blank 1111, frame_valid 0, err 0, err_cnt 00h.
REQ-027 Reset mid-frame SHALL discard the partial frame; no frame_valid is produced for it.

Configuration
REQ-028 Macro SEG_SCAN_DECODER_ERRCNT_EN defined: err_cnt increments on each err pulse, saturates at FFh, clears only on reset.
REQ-029 Macro undefined: err_cnt SHALL be constant 00h and no counter logic SHALL be synthesized; all other behaviour identical.

Verification
REQ-030 Scan digits 0..3 with seg 40h,79h,24h,30h, dig FEh..F7h pattern, 6 cycles each -> one frame_valid, value = 3210h, dp_out 0000, blank 0000.
REQ-031 Digit 2 held only STABLE_CYCLES-1 cycles with 06h -> not accepted; no frame_valid until a stable pass, value unchanged.
REQ-032 Digit 1 shows FFh among hex digits 8,9,A -> value with nibble1 = 0, blank = 0010; digit 0 with 00h (dp lit, 8) -> dp_out bit0 = 1.
REQ-033 Digit 0 shows 7Eh stably -> err pulse, mask bit0 stays clear, err_cnt = 01h with macro, 00h without; 256+ errors -> err_cnt FFh.
REQ-034 dig_in = FCh (two digits low) for 20 cycles -> no accept, no err, FSM WAIT.
REQ-035 rst_n low after three digits accepted, then full clean scan of 5,6,7,8 -> exactly one frame_valid, value = 8765h.
